// File: rtl/ecg_pkg.sv
// Shared widths, depth and entry layout for the ECG sample capture slice.
package ecg_pkg;

   localparam int ECG_DATA_W = 12;
   localparam int ECG_ADDR_W = 12;
   localparam int FIFO_DEPTH = 8;

   typedef struct packed {
      logic                  frame_start;
      logic [ECG_ADDR_W-1:0] addr;
      logic [ECG_DATA_W-1:0] data;
   } ecg_entry_t;

endpackage

// File: rtl/ecg_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on rdata
// whenever empty=0. A push into a full FIFO is accepted only alongside a pop.
module ecg_sync_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]    FULL_LVL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_level == '0);
   assign full      = (r_level == FULL_LVL);
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign rdata     = r_mem[r_rd_ptr];
   assign level     = r_level;

   // NOTE: storage has no reset; occupancy is tracked by the pointers, so stale
   // contents are never observed and the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/ecg_sample_capture.sv
// Captures one {address, sample} entry per sample-strobe rising edge into a FIFO
// and presents it as a valid/ready stream with frame-start and overflow flags.
module ecg_sample_capture
   import ecg_pkg::*;
#(
   parameter int DATA_W = ECG_DATA_W,
   parameter int ADDR_W = ECG_ADDR_W,
   parameter int DEPTH  = FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sample_strobe,
   input  logic [ADDR_W-1:0]      sample_addr,
   input  logic [DATA_W-1:0]      sample_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [ADDR_W-1:0]      out_addr,
   output logic                   out_frame_start,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   input  logic                   clear_ovf
);

   typedef struct packed {
      logic              frame_start;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic              r_s_q1;
   logic              r_s_q2;
   logic              r_edge;
   logic              r_first;
   logic              r_overflow;
   logic [ADDR_W-1:0] r_addr_q;
   logic [DATA_W-1:0] r_data_q;
   entry_t            w_wr_entry;
   entry_t            w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_drop;

   assign w_pop      = ~w_empty & out_ready;
   assign w_drop     = r_edge & w_full & ~w_pop;
   assign w_wr_entry = '{frame_start: (r_addr_q == '0) | r_first,
                         addr:        r_addr_q,
                         data:        r_data_q};

   // Edge is registered so an entry lands two clocks after the strobe is sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_q1     <= 1'b0;
         r_s_q2     <= 1'b0;
         r_edge     <= 1'b0;
         r_addr_q   <= '0;
         r_data_q   <= '0;
         r_first    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_s_q1   <= sample_strobe;
         r_s_q2   <= r_s_q1;
         r_edge   <= r_s_q1 & ~r_s_q2;
         r_addr_q <= sample_addr;
         r_data_q <= sample_data;
         if (r_edge) r_first <= 1'b0;
         if (w_drop)         r_overflow <= 1'b1;
         else if (clear_ovf) r_overflow <= 1'b0;
      end
   end

   ecg_sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (r_edge),
      .pop   (w_pop),
      .wdata (w_wr_entry),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

   // Head fields are masked while empty so the outputs read zero out of reset.
   assign out_valid       = ~w_empty;
   assign out_data        = w_empty ? '0 : w_head.data;
   assign out_addr        = w_empty ? '0 : w_head.addr;
   assign out_frame_start = ~w_empty & w_head.frame_start;
   assign overflow        = r_overflow;

endmodule

// File: tb/tb_ecg_sample_capture.sv
// Directed bench for ecg_sample_capture: table-driven stream vectors plus
// hand-written overflow, full push/pop and asynchronous reset sequences.
module tb_ecg_sample_capture;
   import ecg_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_strobe;
   logic [11:0] sample_addr;
   logic [11:0] sample_data;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic [11:0] out_addr;
   logic        out_frame_start;
   logic [3:0]  level;
   logic        overflow;
   logic        clear_ovf;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic [11:0] addr;
      logic [11:0] data;
      ecg_entry_t  exp;
   } vec_t;

   vec_t vecs[20];

   always #5 clk = ~clk;

   ecg_sample_capture dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sample_strobe   (sample_strobe),
      .sample_addr     (sample_addr),
      .sample_data     (sample_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_addr        (out_addr),
      .out_frame_start (out_frame_start),
      .level           (level),
      .overflow        (overflow),
      .clear_ovf       (clear_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe high two clocks, low two clocks; the push lands on the third edge.
   task automatic capture(input logic [11:0] a, input logic [11:0] d);
      sample_addr   = a;
      sample_data   = d;
      sample_strobe = 1'b1;
      tick();
      tick();
      sample_strobe = 1'b0;
      tick();
      tick();
   endtask

   function automatic vec_t mk(input logic [11:0] a, input logic [11:0] d, input logic fs);
      vec_t v;
      v.addr = a;
      v.data = d;
      v.exp.frame_start = fs;
      v.exp.addr        = a;
      v.exp.data        = d;
      return v;
   endfunction

   initial begin
      for (int i = 0; i < 16; i++)
         vecs[i] = mk(12'(i + 1), 12'(12'h800 + i * 3), 1'b0);
      vecs[16] = mk(12'hFFE, 12'h7E1, 1'b0);
      vecs[17] = mk(12'hFFF, 12'h7E2, 1'b0);
      vecs[18] = mk(12'h000, 12'h7E3, 1'b1);
      vecs[19] = mk(12'h001, 12'h7E4, 1'b0);

      rst_n         = 1'b0;
      sample_strobe = 1'b0;
      sample_addr   = '0;
      sample_data   = '0;
      out_ready     = 1'b0;
      clear_ovf     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst out_valid", 32'(out_valid), 0);
      check("rst level", 32'(level), 0);
      check("rst overflow", 32'(overflow), 0);
      check("rst out_data", 32'(out_data), 0);
      check("rst out_addr", 32'(out_addr), 0);
      check("rst out_fs", 32'(out_frame_start), 0);
      rst_n = 1'b1;
      tick();

      // First capture latency: strobe sampled at P1, entry visible after P3
      sample_addr   = 12'h000;
      sample_data   = 12'h1A5;
      sample_strobe = 1'b1;
      tick();
      check("lat valid k", 32'(out_valid), 0);
      tick();
      check("lat valid k+1", 32'(out_valid), 0);
      sample_strobe = 1'b0;
      tick();
      check("lat valid k+2", 32'(out_valid), 1);
      check("first addr", 32'(out_addr), 32'h000);
      check("first data", 32'(out_data), 32'h1A5);
      check("first fs", 32'(out_frame_start), 1);
      check("first level", 32'(level), 1);
      tick();
      check("first held", 32'(out_data), 32'h1A5);
      out_ready = 1'b1;
      tick();
      check("first popped level", 32'(level), 0);

      // Streaming vectors with the consumer always ready, including address wrap
      for (int i = 0; i < 20; i++) begin
         sample_addr   = vecs[i].addr;
         sample_data   = vecs[i].data;
         sample_strobe = 1'b1;
         tick();
         tick();
         check($sformatf("vec%0d pre level", i), 32'(level), 0);
         sample_strobe = 1'b0;
         tick();
         check($sformatf("vec%0d valid", i), 32'(out_valid), 1);
         check($sformatf("vec%0d addr", i), 32'(out_addr), 32'(vecs[i].exp.addr));
         check($sformatf("vec%0d data", i), 32'(out_data), 32'(vecs[i].exp.data));
         check($sformatf("vec%0d fs", i), 32'(out_frame_start), 32'(vecs[i].exp.frame_start));
         check($sformatf("vec%0d level", i), 32'(level), 1);
         tick();
         check($sformatf("vec%0d drained", i), 32'(level), 0);
      end
      out_ready = 1'b0;

      // Fill to full, then two more captures are dropped
      for (int i = 0; i < 8; i++) capture(12'(12'h020 + i), 12'(12'h300 + i));
      check("full level", 32'(level), 8);
      check("full no ovf", 32'(overflow), 0);
      capture(12'h028, 12'h308);
      check("drop9 level", 32'(level), 8);
      check("drop9 ovf", 32'(overflow), 1);
      capture(12'h029, 12'h309);
      check("drop10 level", 32'(level), 8);
      check("head stable", 32'(out_addr), 32'h020);

      // Full with simultaneous push and pop
      sample_addr   = 12'h030;
      sample_data   = 12'h3F0;
      sample_strobe = 1'b1;
      tick();
      tick();
      sample_strobe = 1'b0;
      out_ready     = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pushpop level", 32'(level), 8);
      check("pushpop ovf", 32'(overflow), 1);
      check("pushpop head", 32'(out_addr), 32'h021);
      tick();

      // Drop in the same cycle as clear_ovf: the set wins
      sample_addr   = 12'h031;
      sample_data   = 12'h3F1;
      sample_strobe = 1'b1;
      tick();
      tick();
      sample_strobe = 1'b0;
      clear_ovf     = 1'b1;
      tick();
      clear_ovf = 1'b0;
      check("clr+drop ovf", 32'(overflow), 1);
      check("clr+drop level", 32'(level), 8);
      tick();
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      check("clear ovf", 32'(overflow), 0);
      capture(12'h032, 12'h3F2);
      check("redrop ovf", 32'(overflow), 1);

      // Drain: 0x021..0x027 then the entry pushed alongside the pop
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [11:0] ea;
         logic [11:0] ed;
         ea = (i < 7) ? 12'(12'h021 + i) : 12'h030;
         ed = (i < 7) ? 12'(12'h301 + i) : 12'h3F0;
         check($sformatf("drain%0d valid", i), 32'(out_valid), 1);
         check($sformatf("drain%0d addr", i), 32'(out_addr), 32'(ea));
         check($sformatf("drain%0d data", i), 32'(out_data), 32'(ed));
         tick();
      end
      check("drain empty", 32'(out_valid), 0);
      check("drain level", 32'(level), 0);
      out_ready = 1'b0;

      // Asynchronous reset with five entries stored and overflow set
      for (int i = 0; i < 5; i++) capture(12'(12'h040 + i), 12'(12'h400 + i));
      check("pre-rst level", 32'(level), 5);
      check("pre-rst ovf", 32'(overflow), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async valid", 32'(out_valid), 0);
      check("async level", 32'(level), 0);
      check("async ovf", 32'(overflow), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      capture(12'h055, 12'h0AB);
      check("post-rst valid", 32'(out_valid), 1);
      check("post-rst addr", 32'(out_addr), 32'h055);
      check("post-rst data", 32'(out_data), 32'h0AB);
      check("post-rst fs", 32'(out_frame_start), 1);
      check("post-rst level", 32'(level), 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ecg_sample_capture.md
Name: ecg_sample_capture

Overview:
- Sits directly downstream of the fetch unit that walks the ECG sample memory.
- Consumes the fetch unit's 12-bit address, its slow sample strobe and the memory read data.
- Turns each strobe rising edge into one {address, sample} entry in a small FIFO.
- Presents the FIFO to the ECG processing chain as a valid/ready stream, flagging frame starts and overflow.

Parameters:
DATA_W, 12, ECG sample width from memory
ADDR_W, 12, sample address width
DEPTH, 8, FIFO entries; power of two, minimum 2

Ports:
clk  in  1  system clock; the fetch unit is clocked from it too
rst_n  in  1  reset, asynchronous assert, active-low
sample_strobe  in  1  sample strobe from fetch unit; one capture per rising edge
sample_addr  in  ADDR_W  address currently driven to sample memory
sample_data  in  DATA_W  memory read data for sample_addr
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_data  out  DATA_W  head sample
out_addr  out  ADDR_W  head address
out_frame_start  out  1  head entry starts a frame
level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a capture was dropped
clear_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (rst_n=0, async): all of the following go to 0 and hold:
  - FIFO pointers and level
  - out_valid, out_data, out_addr, out_frame_start
  - overflow
  - strobe pipeline (s_q1, s_q2)
  - the first-capture flag is set to 1.
- Reset mid-operation discards all stored entries. The first capture after release is flagged as a frame start.
- Input stage, every clk posedge:
  - s_q1<=sample_strobe, s_q2<=s_q1.
  - addr_q<=sample_addr, data_q<=sample_data.
  - edge = s_q1 & ~s_q2.
- Input contract: sample_addr/sample_data are stable from 1 clk before the strobe rise until 1 clk after it.
- Push: on edge, entry {addr_q, data_q, fs} is written, where fs = (addr_q==0) | first-capture flag. The first-capture flag then clears.
- Latency: strobe sampled high at posedge k → edge at k+1 → entry written at posedge k+2. With an empty FIFO, out_valid=1 after posedge k+2.
- Output is a first-word-fall-through FIFO:
  - out_data/out_addr/out_frame_start show the head entry whenever out_valid=1.
  - Pop occurs on a posedge with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, the head entry holds stable.
- level counts entries. out_valid = (level!=0).
- Simultaneous push and pop:
  - Empty FIFO: push only; a pop is impossible because out_valid=0.
  - Non-empty, including full: both occur and level is unchanged.
- Full (level==DEPTH) with push and no pop: the entry is dropped, overflow<=1, FIFO contents unchanged.
- overflow: clear_ovf=1 clears it on the next posedge. If a drop occurs in the same cycle as clear_ovf, overflow stays 1; the set wins.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level saturates only by construction: no push when full without a pop.
- Address wrap (fetch unit returns to 0) needs no special handling beyond fs. Non-consecutive addresses are passed through unchanged.
- Strobe held high produces exactly one capture. A strobe glitch shorter than one clk may be missed; this is acceptable.

Decomposition:
- Shared package ecg_pkg holds:
  - DATA_W and ADDR_W defaults
  - the packed entry typedef ecg_entry_t {frame_start, addr, data}
  - FIFO_DEPTH default
- Natural sub-module: ecg_sync_fifo, parameterised by width and depth.
  - Provides push, pop, full, empty, level and a FWFT head.
- ecg_sample_capture keeps the strobe edge detect, input registers, frame-start and overflow logic.

Test Plan:
- Reset release, then strobe rise with addr=0x000, data=0x1A5 → out_valid=1 two clocks after strobe sampled; out_addr=0x000, out_data=0x1A5, out_frame_start=1, level=1.
- out_ready=1, strobe toggling every 2 clks, addresses 0x001..0x010 → 16 entries out in order; out_frame_start=0 for all; level never exceeds 1.
- out_ready=0, 10 strobe edges, DEPTH=8 → level=8, overflow=1, and the first 8 addresses pop in order once out_ready=1; entries 9 and 10 are absent.
- Full FIFO, push and pop in the same cycle → level stays 8, the new entry appears last, overflow unchanged; clear_ovf pulsed together with a drop → overflow remains 1.
- Addresses 0xFFE, 0xFFF, 0x000, 0x001 → out_frame_start=1 only on the 0x000 entry.
- rst_n asserted asynchronously with level=5 → out_valid, level, overflow go to 0 immediately; the next capture has out_frame_start=1.
